// File: rtl/ssd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : ssd_scan_controller
// Purpose  : Frame-synchronous digit scan, PWM brightness, blanking and
//            tear-free content updates for an 8-digit seven-segment display.
// Revision : 1.0 - initial release
// ============================================================================
module ssd_scan_controller #(
    parameter int PRESCALE   = 100000,
    parameter int NUM_DIGITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic [7:0]  blank_mask_in,
    input  logic [3:0]  brightness_in,
    input  logic        upd_valid,
    output logic        upd_ready,
    output logic [2:0]  sel,
    output logic [3:0]  digit,
    output logic [7:0]  AN,
    output logic        frame_done
);

    localparam int                c_PS_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PS_W-1:0] c_PS_MAX     = c_PS_W'(PRESCALE - 1);
    localparam logic [2:0]        c_SEL_MAX    = 3'(NUM_DIGITS - 1);
    localparam logic [3:0]        c_SLOT_MAX   = 4'd15;
    localparam logic [0:0]        c_ST_EMPTY   = 1'b0;
    localparam logic [0:0]        c_ST_PENDING = 1'b1;

    logic [c_PS_W-1:0] r_ps;
    logic [3:0]        r_slot;
    logic [2:0]        r_sel;
    logic              r_frame_done;
    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;

    logic [31:0]       r_pend_data;
    logic [7:0]        r_pend_mask;
    logic [3:0]        r_pend_bright;
    logic [31:0]       r_act_data;
    logic [7:0]        r_act_mask;
    logic [3:0]        r_act_bright;

    logic              w_tick;
    logic              w_wrap;
    logic              w_capture;
    logic              w_apply;
    logic [7:0]        w_an;

    assign w_tick = (r_ps == c_PS_MAX);
    assign w_wrap = w_tick && (r_slot == c_SLOT_MAX) && (r_sel == c_SEL_MAX);

    // Update handshake: capture only when empty, promote only at a frame wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_apply     = 1'b0;
        case (r_state)
            c_ST_EMPTY: begin
                if (upd_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_ST_PENDING;
                end
            end
            c_ST_PENDING: begin
                if (w_wrap) begin
                    w_apply     = 1'b1;
                    w_state_nxt = c_ST_EMPTY;
                end
            end
            default: w_state_nxt = c_ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ps          <= '0;
            r_slot        <= '0;
            r_sel         <= '0;
            r_frame_done  <= 1'b0;
            r_state       <= c_ST_EMPTY;
            r_pend_data   <= '0;
            r_pend_mask   <= '0;
            r_pend_bright <= '0;
            r_act_data    <= '0;
            r_act_mask    <= 8'hFF;
            r_act_bright  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_wrap;
            r_ps         <= w_tick ? '0 : r_ps + 1'b1;
            if (w_tick) begin
                r_slot <= r_slot + 1'b1;
                if (r_slot == c_SLOT_MAX) begin
                    r_sel <= (r_sel == c_SEL_MAX) ? 3'd0 : r_sel + 3'd1;
                end
            end
            if (w_capture) begin
                r_pend_data   <= data_in;
                r_pend_mask   <= blank_mask_in;
                r_pend_bright <= brightness_in;
            end
            if (w_apply) begin
                r_act_data   <= r_pend_data;
                r_act_mask   <= r_pend_mask;
                r_act_bright <= r_pend_bright;
            end
        end
    end

    // Slot 0 is a guard tick so sel/digit settle with every anode off.
    always_comb begin
        w_an = 8'hFF;
        if ((r_slot != 4'd0) && (r_slot <= r_act_bright) && !r_act_mask[r_sel]) begin
            w_an[r_sel] = 1'b0;
        end
    end

    assign AN         = w_an;
    assign sel        = r_sel;
    assign digit      = r_act_data[4*r_sel +: 4];
    assign frame_done = r_frame_done;
    assign upd_ready  = (r_state == c_ST_EMPTY);

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssd_scan_controller
// Purpose  : Randomized bench for two scan controller configurations against
//            a time-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_controller;

    localparam int c_P0 = 2;
    localparam int c_N0 = 8;
    localparam int c_P1 = 1;
    localparam int c_N1 = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic [7:0]  blank_mask_in;
    logic [3:0]  brightness_in;
    logic        upd_valid;

    logic        ready_a, ready_b;
    logic [2:0]  sel_a, sel_b;
    logic [3:0]  digit_a, digit_b;
    logic [7:0]  an_a, an_b;
    logic        fd_a, fd_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ssd_scan_controller #(.PRESCALE(c_P0), .NUM_DIGITS(c_N0)) u_dut_a (
        .clk(clk), .reset(reset), .data_in(data_in), .blank_mask_in(blank_mask_in),
        .brightness_in(brightness_in), .upd_valid(upd_valid), .upd_ready(ready_a),
        .sel(sel_a), .digit(digit_a), .AN(an_a), .frame_done(fd_a)
    );

    ssd_scan_controller #(.PRESCALE(c_P1), .NUM_DIGITS(c_N1)) u_dut_b (
        .clk(clk), .reset(reset), .data_in(data_in), .blank_mask_in(blank_mask_in),
        .brightness_in(brightness_in), .upd_valid(upd_valid), .upd_ready(ready_b),
        .sel(sel_b), .digit(digit_b), .AN(an_b), .frame_done(fd_b)
    );

    // Reference model: position in time is cycles-since-reset; displayed
    // content is tracked as active/pending snapshots.
    int          m_p  [2] = '{c_P0, c_P1};
    int          m_nd [2] = '{c_N0, c_N1};
    int          m_n  [2];
    bit          m_pending [2];
    logic [31:0] m_pdata [2], m_adata [2];
    logic [7:0]  m_pmask [2], m_amask [2];
    logic [3:0]  m_pbright [2], m_abright [2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input int i);
        int period;
        period = 16 * m_nd[i] * m_p[i];
        if (!reset) begin
            m_n[i]       = 0;
            m_pending[i] = 0;
            m_adata[i]   = '0;
            m_amask[i]   = 8'hFF;
            m_abright[i] = '0;
        end else begin
            if (!m_pending[i]) begin
                if (upd_valid) begin
                    m_pending[i] = 1;
                    m_pdata[i]   = data_in;
                    m_pmask[i]   = blank_mask_in;
                    m_pbright[i] = brightness_in;
                end
            end else if ((m_n[i] + 1) % period == 0) begin
                m_pending[i] = 0;
                m_adata[i]   = m_pdata[i];
                m_amask[i]   = m_pmask[i];
                m_abright[i] = m_pbright[i];
            end
            m_n[i]++;
        end
    endtask

    task automatic model_check(input int i, input logic [2:0] s_obs, input logic [3:0] d_obs,
                               input logic [7:0] an_obs, input logic fd_obs, input logic rdy_obs);
        int          period, ticks, slot, s;
        logic [7:0]  exp_an;
        string       pre;
        pre    = (i == 0) ? "a_" : "b_";
        period = 16 * m_nd[i] * m_p[i];
        ticks  = m_n[i] / m_p[i];
        slot   = ticks % 16;
        s      = (ticks / 16) % m_nd[i];
        exp_an = 8'hFF;
        if (slot >= 1 && slot <= int'(m_abright[i]) && !m_amask[i][s]) exp_an[s] = 1'b0;
        check_eq({pre, "sel"}, 32'(s_obs), 32'(s));
        check_eq({pre, "an"}, 32'(an_obs), 32'(exp_an));
        check_eq({pre, "frame_done"}, 32'(fd_obs), 32'((m_n[i] > 0) && (m_n[i] % period == 0)));
        check_eq({pre, "upd_ready"}, 32'(rdy_obs), 32'(!m_pending[i]));
        if (exp_an != 8'hFF || m_n[i] == 0) begin
            check_eq({pre, "digit"}, 32'(d_obs), 32'(m_adata[i][4*s +: 4]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        model_check(0, sel_a, digit_a, an_a, fd_a, ready_a);
        model_check(1, sel_b, digit_b, an_b, fd_b, ready_b);
    endtask

    // Waits for controller A to be ready (optionally also on its last
    // pre-wrap cycle) and presents a single-cycle request.
    task automatic do_update(input logic [31:0] d, input logic [7:0] m, input logic [3:0] b,
                             input bit at_wrap);
        int guard;
        guard = 0;
        while (!(ready_a && (!at_wrap || (m_n[0] % (16 * c_N0 * c_P0) == 16 * c_N0 * c_P0 - 1)))
               && guard < 2000) begin
            step();
            guard++;
        end
        check_eq("wait_ready_a", 32'(ready_a), 32'd1);
        data_in       = d;
        blank_mask_in = m;
        brightness_in = b;
        upd_valid     = 1'b1;
        step();
        upd_valid     = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        upd_valid     = 1'b0;
        data_in       = '0;
        blank_mask_in = '0;
        brightness_in = '0;
        repeat (3) step();
        reset = 1'b1;

        // Idle scan: dark display, free-running sel and frame pulses.
        repeat (512) step();

        // Full brightness, all digits enabled.
        do_update(32'h7654_3210, 8'h00, 4'd15, 1'b0);
        repeat (600) step();

        // Request landing on the frame-wrap cycle waits one full frame.
        do_update(32'hFEDC_BA98, 8'h00, 4'd9, 1'b1);
        repeat (600) step();

        // Partial blanking at low brightness, then fully dark.
        do_update(32'h1357_9BDF, 8'hA5, 4'd4, 1'b0);
        repeat (600) step();
        do_update(32'h2468_ACE0, 8'h00, 4'd0, 1'b0);
        repeat (600) step();

        // Second request while pending is ignored.
        do_update(32'h0123_4567, 8'h00, 4'd12, 1'b0);
        data_in   = 32'h89AB_CDEF;
        upd_valid = 1'b1;
        repeat (5) step();
        upd_valid = 1'b0;
        repeat (600) step();

        // Reset mid-frame with an update pending discards it.
        do_update(32'h5555_AAAA, 8'h00, 4'd15, 1'b0);
        repeat (70) step();
        reset     = 1'b0;
        upd_valid = 1'b1;
        step();
        reset     = 1'b1;
        upd_valid = 1'b0;
        repeat (600) step();

        for (int k = 0; k < 30; k++) begin
            do_update($urandom, 8'($urandom), 4'($urandom_range(0, 15)), bit'($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 400)) step();
            if ($urandom_range(0, 7) == 0) begin
                reset = 1'b0;
                repeat ($urandom_range(1, 3)) step();
                reset = 1'b1;
            end
        end
        repeat (300) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ssd_scan_controller.md
Name: ssd_scan_controller

Overview:
- Frame-synchronous scan scheduler for the 8-digit seven-segment display.
- Owns digit-select sequencing, anode timing, per-digit blanking and PWM brightness.
- Accepts new display contents through a valid/ready handshake and applies them only at frame boundaries, so frames never tear.
- Replaces the free-running divider/counter pair in front of the digit mux and segment decoder. The digit output feeds the segment decoder directly.

Parameters:
PRESCALE, 100000, system clocks per scan tick (legal range >= 1)
NUM_DIGITS, 8, digits scanned per frame (legal range 2..8)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
data_in  input  32  packed nibbles; digit k = data_in[4k+3:4k]
blank_mask_in  input  8  bit k = 1 forces digit k dark
brightness_in  input  4  on-ticks per digit slot, 0..15
upd_valid  input  1  update request; data_in, blank_mask_in and brightness_in are valid
upd_ready  output  1  controller can accept an update
sel  output  3  current digit index, to the digit mux
digit  output  4  active nibble for the current digit
AN  output  8  anodes, active-low, at most one bit low
frame_done  output  1  one-cycle pulse at frame wrap

Behaviour:
- Reset (reset=0 at a clock edge) sets, on that edge:
  - prescaler=0, slot_cnt=0, sel=0, AN=8'hFF, digit=0, frame_done=0, upd_ready=1
  - active data=0, active mask=8'hFF, active brightness=0, pending registers cleared, update FSM=EMPTY
- Reset mid-frame or mid-handshake discards any pending update.
- Prescaler:
  - Counts 0..PRESCALE-1.
  - tick=1 on the cycle the count equals PRESCALE-1; the count wraps to 0 on the same edge.
  - PRESCALE=1 gives tick on every cycle.
- Slot timing:
  - slot_cnt (4 bits) advances on each tick, 0..15.
  - On a tick with slot_cnt=15: slot_cnt goes to 0 and sel increments.
  - sel wraps from NUM_DIGITS-1 to 0.
- Anode rule:
  - AN[sel]=0 iff 1 <= slot_cnt <= active brightness AND active mask[sel]=0.
  - All other AN bits are 1.
  - slot_cnt=0 is a guard tick: all anodes are off while sel/digit settle, which prevents ghosting.
  - brightness=0 gives a dark display; 15 gives a 15/16 duty.
- digit = active data nibble [sel]. Output while the anode is off is don't-care but must stay stable within a slot.
- Output timing: sel, digit, AN and frame_done are registered, or are functions of registered state only. There is no combinational path from any input to any output.
- Frame wrap: the tick with sel=NUM_DIGITS-1 and slot_cnt=15.
  - frame_done=1 for exactly the following cycle.
- Update FSM, two states:
  - EMPTY (upd_ready=1):
    - upd_valid=1 captures data_in, blank_mask_in and brightness_in into the pending registers.
    - Next state is PENDING; upd_ready=0 from the next cycle.
  - PENDING (upd_ready=0):
    - At frame wrap, pending copies to active on the wrap edge, effective from the first slot of the new frame.
    - Next state is EMPTY; upd_ready=1 the cycle after the wrap.
  - upd_valid is ignored while in PENDING. Requesters must hold upd_valid until they see upd_ready.
- Simultaneous events:
  - Acceptance in EMPTY on the frame-wrap cycle does not apply in that wrap. It goes PENDING and applies at the next wrap. Latency is therefore exactly one full frame.
  - Reset asserted together with upd_valid: reset wins; nothing is captured.
- Frame period = 16 * NUM_DIGITS * PRESCALE clocks.
- Unused mask bits >= NUM_DIGITS are ignored.

Test Plan:
1. Reset then release, PRESCALE=2, no updates:
   - AN stays 8'hFF for 2 full frames.
   - sel steps 0..7 every 32 clocks.
   - frame_done pulses every 256 clocks.
   - upd_ready=1 throughout.
2. Update data_in=32'h76543210, mask=8'h00, brightness=15; wait one frame:
   - Per digit k: AN low at bit k for slot_cnt 1..15 (30 clocks), high during slot 0.
   - digit=k while AN is low.
   - Never more than one AN bit low.
3. Update on the exact frame-wrap cycle:
   - Accepted: upd_ready drops next cycle.
   - Old contents are displayed for the entire next frame; the new contents appear only after the second wrap.
   - upd_ready returns one cycle after that wrap.
4. brightness=4, mask=8'b1010_0101:
   - Digits 0, 2, 5, 7 are never lit.
   - Digits 1, 3, 4, 6 are lit exactly for slot_cnt 1..4.
   - brightness=0 gives AN=8'hFF for a full frame.
5. Second upd_valid while PENDING with different data:
   - Ignored; only the first data is applied.
   - Assert reset mid-frame: next edge gives AN=8'hFF, sel=0, upd_ready=1, and the pending data is lost.
6. PRESCALE=1, NUM_DIGITS=4:
   - sel cycles 0..3 only.
   - Frame period = 64 clocks.
   - frame_done pulse width is exactly 1 cycle.
